result_uart_tx: RTL

// Host-facing readout path for the processor's ten 32-bit debug outputs. It works

---
 rtl/riscv_dbg_pkg.sv | 23 ++
 rtl/uart_tx_byte.sv | 112 +++++++++++
 rtl/result_uart_tx.sv | 99 +++++++++
 3 files changed

// File: rtl/riscv_dbg_pkg.sv
// Shared constants, types and helpers for the debug readout path.
//   SYNC_BYTE            first byte of every frame, lets the host re-sync
//   UART_BITS_PER_FRAME  start + 8 data + stop
//   uart_state_e         bit-level state of the byte serializer
//   frame_bytes(n)       bytes per frame for n 32-bit words (sync + data + checksum)
package riscv_dbg_pkg;

  localparam logic [7:0]  SYNC_BYTE           = 8'hA5;
  localparam int unsigned UART_BITS_PER_FRAME = 10;
  localparam int unsigned UART_DATA_BITS      = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START_BIT = 2'd1,
    ST_DATA_BITS = 2'd2,
    ST_STOP_BIT  = 2'd3
  } uart_state_e;

  function automatic int unsigned frame_bytes(input int unsigned n);
    return n * 4 + 2;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first, idle high.
//   clock, reset    system clock, async active-low reset
//   load, data      accepted when idle or on the last clock of a stop bit
//   tx              UART line (flop output)
//   ready           high when a load will be accepted at the next edge
//   byte_done       one-clock pulse during the final clock of the stop bit,
//                   so a load issued alongside it chains bytes with no gap
module uart_tx_byte
  import riscv_dbg_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready,
  output logic       byte_done
);

  localparam int unsigned     CNT_W       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRELAST = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [2:0]       BIT_LAST    = 3'(UART_DATA_BITS - 1);

  uart_state_e      state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             baud_tick_c;

  assign baud_tick_c = (baud_cnt == CNT_LAST);

  // Bit FSM with baud counter; tx/ready/byte_done are all registered here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
      ready     <= 1'b1;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          if (load) begin
            state     <= ST_START_BIT;
            shift_reg <= data;
            tx        <= 1'b0;
            ready     <= 1'b0;
          end
        end
        ST_START_BIT: begin
          if (baud_tick_c) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shift_reg[0];
            state    <= ST_DATA_BITS;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        ST_DATA_BITS: begin
          if (baud_tick_c) begin
            baud_cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              tx    <= 1'b1;
              state <= ST_STOP_BIT;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              shift_reg <= {1'b0, shift_reg[7:1]};
              tx        <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        ST_STOP_BIT: begin
          if (baud_tick_c) begin
            baud_cnt <= '0;
            if (load) begin
              state     <= ST_START_BIT;
              shift_reg <= data;
              tx        <= 1'b0;
              ready     <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
            // Announce the last stop-bit clock so the next byte can be loaded on its closing edge.
            if (baud_cnt == CNT_PRELAST) begin
              byte_done <= 1'b1;
              ready     <= 1'b1;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          baud_cnt <= '0;
          tx       <= 1'b1;
          ready    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/result_uart_tx.sv
// Snapshots NUM_WORDS debug words and sends them as one UART frame:
// 0xA5, word0 byte0..3 (little-endian), ..., word N-1, XOR checksum of data bytes.
//   clock, reset  system clock, async active-low reset
//   start         frame request, accepted only when not busy
//   result_bus    word k at [32k+31:32k]
//   tx            UART line, 8N1
//   busy          accepted start through end of the last stop bit
//   done          one-clock pulse after the last stop bit
module result_uart_tx
  import riscv_dbg_pkg::*;
#(
  parameter int unsigned NUM_WORDS    = 10,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NUM_WORDS*32-1:0] result_bus,
  output logic                    tx,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned      DATA_BYTES = NUM_WORDS * 4;
  localparam int unsigned      NUM_BYTES  = frame_bytes(NUM_WORDS);
  localparam int unsigned      IDX_W      = $clog2(NUM_BYTES);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_BYTES - 1);
  localparam logic [IDX_W-1:0] IDX_CSUM_N = IDX_W'(DATA_BYTES);

  logic [DATA_BYTES-1:0][7:0] snapshot;
  logic [IDX_W-1:0]           byte_idx;
  logic [7:0]                 checksum;

  logic       byte_ready;
  logic       byte_done;
  logic       accept_c;
  logic       advance_c;
  logic       last_byte_c;
  logic       next_is_csum_c;
  logic       load_c;
  logic [7:0] load_data_c;

  assign accept_c       = start & ~busy & byte_ready;
  assign last_byte_c    = (byte_idx == IDX_LAST);
  assign advance_c      = busy & byte_done & ~last_byte_c;
  assign next_is_csum_c = (byte_idx == IDX_CSUM_N);
  assign load_c         = accept_c | advance_c;

  // Byte to hand the serializer: sync on accept, else data byte byte_idx or the checksum.
  always_comb begin
    load_data_c = SYNC_BYTE;
    if (advance_c) begin
      load_data_c = next_is_csum_c ? checksum : snapshot[byte_idx];
    end
  end

  // Frame control: snapshot, byte index, running checksum, busy/done.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      snapshot <= '0;
      byte_idx <= '0;
      checksum <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept_c) begin
        snapshot <= result_bus;
        byte_idx <= '0;
        checksum <= '0;
        busy     <= 1'b1;
      end else if (busy && byte_done) begin
        if (last_byte_c) begin
          busy     <= 1'b0;
          done     <= 1'b1;
          byte_idx <= '0;
        end else begin
          byte_idx <= byte_idx + IDX_W'(1);
          if (!next_is_csum_c) begin
            checksum <= checksum ^ snapshot[byte_idx];
          end
        end
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte (
    .clock     (clock),
    .reset     (reset),
    .load      (load_c),
    .data      (load_data_c),
    .tx        (tx),
    .ready     (byte_ready),
    .byte_done (byte_done)
  );

endmodule
